// File: rtl/pc_pkg.sv
// Shared PC sequencer definitions: next-PC source encoding, instruction size, source resolver.
// Latency: none, declarations and a pure combinational helper only.
// Backpressure: not applicable, no handshake lives here.
package pc_pkg;

    // Every instruction is one fixed-size word; sequential flow and return addresses step by this.
    localparam int ILEN_BYTES = 4;

    // Next-PC source, listed from lowest to highest priority.
    typedef enum logic [2:0] {
        HOLD = 3'd0,
        INC  = 3'd1,
        BR   = 3'd2,
        JMP  = 3'd3,
        RET  = 3'd4
    } pc_sel_e;

    // Fixed priority: return beats jump beats branch beats increment; nothing asserted means hold.
    function automatic pc_sel_e resolve_sel(
        input logic ret_en,
        input logic jump_en,
        input logic branch_en,
        input logic increment_en
    );
        pc_sel_e sel;
        if (ret_en) begin
            sel = RET;
        end else if (jump_en) begin
            sel = JMP;
        end else if (branch_en) begin
            sel = BR;
        end else if (increment_en) begin
            sel = INC;
        end else begin
            sel = HOLD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push/pop with a saturating occupancy count.
// Latency: push/pop take effect on the next rising edge; top/empty/full are combinational.
// Backpressure: none; a push when full overwrites the oldest entry, a pop when empty is ignored.
module ras_stack
    import pc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4   // power of two, at least 2, so the pointer wraps naturally
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage carries no reset: only the pointer and count define what is valid.
    logic [XLEN-1:0]  entries [RAS_DEPTH];

    // wr_ptr names the slot the next push lands in; the live top sits one below it.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic [CNT_W-1:0] count;
    logic             do_pop;
    logic             do_push;

    assign top_ptr = wr_ptr - PTR_W'(1);
    assign top     = entries[top_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RAS_DEPTH));

    // Popping an empty stack is meaningless, so it never moves the pointer or count.
    assign do_pop  = pop && !empty;
    // Writes are suppressed during reset so an operation in flight leaves no trace.
    assign do_push = push && !rst;

    // Push together with pop replaces the top in place; a plain push claims the next slot.
    assign wr_idx  = do_pop ? top_ptr : wr_ptr;

    // Pointer and occupancy: push advances, pop retreats, both together leave them unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push && !do_pop) begin
            // When full the pointer still advances, landing on (and overwriting) the oldest entry.
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (!push && do_pop) begin
            wr_ptr <= top_ptr;
            count  <= count - CNT_W'(1);
        end
    end

    // Entry write port.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: increment, PC-relative branch, register-indirect jump, call/return via RAS.
// Latency: the next-PC chosen in cycle N is visible on pc in cycle N+1; misaligned/ret_miss pulse in N+1.
// Backpressure: none; every enable combination is resolved in a single cycle, all-low holds state.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            increment_en,
    input  logic            branch_en,
    input  logic [XLEN-1:0] branch_offset,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_base,
    input  logic [XLEN-1:0] jump_offset,
    input  logic            call_en,
    input  logic            ret_en,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned,
    output logic            ret_miss,
    output logic            ras_empty,
    output logic            ras_full
);

    pc_sel_e         sel;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jmp_sum;
    logic [XLEN-1:0] jmp_target;
    logic [XLEN-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic            misaligned_next;
    logic            ret_miss_next;

    // All address arithmetic wraps modulo 2^XLEN without any flag.
    assign pc_plus4   = pc + XLEN'(ILEN_BYTES);
    assign br_target  = pc + branch_offset;
    assign jmp_sum    = jump_base + jump_offset;
    // Bit 0 of an indirect target is dropped so odd base registers still land on a halfword.
    assign jmp_target = jmp_sum & ~XLEN'(1);

    // Resolve the PC source, the next PC, RAS traffic and the pulse flags for this cycle.
    always_comb begin
        sel             = resolve_sel(ret_en, jump_en, branch_en, increment_en);
        pc_next         = pc;
        ras_push        = 1'b0;
        ras_pop         = 1'b0;
        misaligned_next = 1'b0;
        ret_miss_next   = 1'b0;

        case (sel)
            RET: begin
                if (!ras_empty) begin
                    // Popped targets were pushed as pc+4 and are trusted without an alignment check.
                    pc_next  = ras_top;
                    ras_pop  = 1'b1;
                    // A return that is also a call swaps the top for the new return address.
                    ras_push = call_en;
                end else begin
                    // Empty stack: fall through sequentially and flag the miss.
                    pc_next       = pc_plus4;
                    ret_miss_next = 1'b1;
                end
            end
            JMP: begin
                if (jmp_target[1]) begin
                    // Rejected target: pc holds and no return address is recorded.
                    misaligned_next = 1'b1;
                end else begin
                    pc_next  = jmp_target;
                    ras_push = call_en;
                end
            end
            BR: begin
                if (br_target[1]) begin
                    misaligned_next = 1'b1;
                end else begin
                    pc_next  = br_target;
                    ras_push = call_en;
                end
            end
            INC: begin
                pc_next = pc_plus4;
            end
            default: begin
                pc_next = pc;
            end
        endcase
    end

    // PC register and the one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_VECTOR;
            misaligned <= 1'b0;
            ret_miss   <= 1'b0;
        end else begin
            pc         <= pc_next;
            misaligned <= misaligned_next;
            ret_miss   <= ret_miss_next;
        end
    end

    // The return address pushed is always the one following the current PC.
    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: table of vectors applied through a scoreboard queue, plus hand sequences.
// Latency: each vector is checked #1 after the rising edge that consumes it.
// Backpressure: not applicable.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        increment_en;
    logic        branch_en;
    logic [31:0] branch_offset;
    logic        jump_en;
    logic [31:0] jump_base;
    logic [31:0] jump_offset;
    logic        call_en;
    logic        ret_en;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic        ret_miss;
    logic        ras_empty;
    logic        ras_full;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        inc;
        logic        br;
        logic [31:0] boff;
        logic        jmp;
        logic [31:0] jbase;
        logic [31:0] joff;
        logic        call;
        logic        ret;
        logic [31:0] pc;
        logic        mis;
        logic        miss;
        logic        empty;
        logic        full;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    pc_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .RAS_DEPTH    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .increment_en  (increment_en),
        .branch_en     (branch_en),
        .branch_offset (branch_offset),
        .jump_en       (jump_en),
        .jump_base     (jump_base),
        .jump_offset   (jump_offset),
        .call_en       (call_en),
        .ret_en        (ret_en),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .misaligned    (misaligned),
        .ret_miss      (ret_miss),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(
        input logic inc, br, input logic [31:0] boff,
        input logic jmp, input logic [31:0] jbase, joff,
        input logic call, ret, input logic [31:0] exp_pc,
        input logic mis, miss, empty, full
    );
        vec_t v;
        v.inc = inc;   v.br = br;       v.boff = boff;
        v.jmp = jmp;   v.jbase = jbase; v.joff = joff;
        v.call = call; v.ret = ret;     v.pc = exp_pc;
        v.mis = mis;   v.miss = miss;   v.empty = empty; v.full = full;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        increment_en  = 1'b0;
        branch_en     = 1'b0;
        branch_offset = '0;
        jump_en       = 1'b0;
        jump_base     = '0;
        jump_offset   = '0;
        call_en       = 1'b0;
        ret_en        = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        increment_en  = v.inc;
        branch_en     = v.br;
        branch_offset = v.boff;
        jump_en       = v.jmp;
        jump_base     = v.jbase;
        jump_offset   = v.joff;
        call_en       = v.call;
        ret_en        = v.ret;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".pc"},       pc,                 e.pc);
        check({tag, ".pc_plus4"}, pc_plus4,           e.pc + 32'd4);
        check({tag, ".mis"},      32'(misaligned),    32'(e.mis));
        check({tag, ".miss"},     32'(ret_miss),      32'(e.miss));
        check({tag, ".empty"},    32'(ras_empty),     32'(e.empty));
        check({tag, ".full"},     32'(ras_full),      32'(e.full));
    endtask

    initial begin
        //                inc br boff          jmp jbase         joff          call ret exp_pc        mis miss emp full
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 32'h0000_0004, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 32'h0000_0008, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 32'h0000_000C, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h100,      32'h0,        0, 0, 32'h0000_0100, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFF0, 0, 32'h0,       32'h0,        0, 0, 32'h0000_00F0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h100,      32'h0,        0, 0, 32'h0000_0100, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h6,        0, 32'h0,        32'h0,        0, 0, 32'h0000_0100, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 32'h0000_0100, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h201,      32'h0,        0, 0, 32'h0000_0200, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'h0,       0, 0, 32'hFFFF_FFFC, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 32'h0000_0000, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h40,       32'h0,        0, 0, 32'h0000_0040, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h80,       32'h0,        1, 0, 32'h0000_0080, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1, 32'h0000_0044, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1, 32'h0000_0048, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 32'h0000_0048, 0, 0, 1, 0));
        // misaligned call target: no push
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h102,      32'h0,        1, 0, 32'h0000_0048, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h200,      32'h0,        1, 0, 32'h0000_0200, 0, 0, 0, 0));
        // return+call: jump to 0x4C, top becomes 0x204
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 1, 32'h0000_004C, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1, 32'h0000_0204, 0, 0, 1, 0));
        // priority: jump over branch, branch over increment, return over jump
        tbl.push_back(mk(0, 1, 32'h100,      1, 32'h10,       32'h0,        0, 0, 32'h0000_0010, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 32'h20,       0, 32'h0,        32'h0,        0, 0, 32'h0000_0030, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFD0, 0, 32'h0,       32'h0,        1, 0, 32'h0000_0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h500,      32'h0,        0, 1, 32'h0000_0034, 0, 0, 1, 0));
        // jump sum spread over base and offset
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h0FFF,     32'h1,        0, 0, 32'h0000_1000, 0, 0, 1, 0));

        rst = 1'b1;
        idle_inputs();
        #1;
        check("reset.pc",    pc,               32'h0);
        check("reset.mis",   32'(misaligned),  32'd0);
        check("reset.miss",  32'(ret_miss),    32'd0);
        check("reset.empty", 32'(ras_empty),   32'd1);
        check("reset.full",  32'(ras_full),    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Five nested calls from 0x1000 into a four-deep stack, then unwind.
        for (int k = 0; k < 5; k++) begin
            apply(mk(0, 1, 32'h10, 0, 32'h0, 32'h0, 1, 0,
                     32'h1000 + 32'((k + 1) * 16), 0, 0, 0, (k >= 3)),
                  $sformatf("call%0d", k));
        end
        for (int k = 0; k < 4; k++) begin
            apply(mk(0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1,
                     32'h1044 - 32'(k * 16), 0, 0, (k == 3), 0),
                  $sformatf("ret%0d", k));
        end
        apply(mk(0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 32'h1018, 0, 1, 1, 0), "ret_oldest_gone");

        // Fill one entry, then assert reset mid-cycle with a misaligned branch pending.
        apply(mk(0, 0, 32'h0, 1, 32'h300, 32'h0, 1, 0, 32'h300, 0, 0, 0, 0), "pre_rst");
        @(negedge clk);
        branch_en     = 1'b1;
        branch_offset = 32'h6;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async.pc",    pc,              32'h0);
        check("rst_async.empty", 32'(ras_empty),  32'd1);
        check("rst_async.mis",   32'(misaligned), 32'd0);
        @(posedge clk);
        #1;
        check("rst_edge.pc",   pc,              32'h0);
        check("rst_edge.mis",  32'(misaligned), 32'd0);
        check("rst_edge.miss", 32'(ret_miss),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        increment_en = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst.pc", pc, 32'h4);
        idle_inputs();

        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
